matvec_engine: RTL and testbench

MATVEC_ENGINE -- requirements
Module: matvec_engine

---
 rtl/matvec_engine.sv | 180 ++++++++++++++++++
 tb/tb_matvec_engine.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matvec_engine                                                            |
// | ROWS-lane saturating MAC engine: streams COLS beats, returns C = A*B.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module matvec_engine #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic                                         signed_mode,
  input  logic                                         abort,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [ROWS*DATA_W-1:0]                       in_a,
  input  logic [DATA_W-1:0]                            in_b,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [ACC_W-1:0]                             out_data,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0]   out_row,
  output logic                                         out_last,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         ovf
);
  localparam int c_row_w  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int c_cnt_w  = $clog2(COLS + 1);
  localparam int c_prod_w = 2 * DATA_W;

  localparam logic [c_cnt_w-1:0] c_cols      = c_cnt_w'(COLS);
  localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(COLS - 1);
  localparam logic [c_row_w-1:0] c_last_row  = c_row_w'(ROWS - 1);
  localparam logic [ACC_W-1:0]   c_smax      = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]   c_smin      = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0]   c_umax      = {ACC_W{1'b1}};

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_accum  = 2'd1;
  localparam logic [1:0] c_st_drain  = 2'd2;
  localparam logic [1:0] c_st_output = 2'd3;

  logic [1:0]               r_state;
  logic [c_cnt_w-1:0]       r_beat_cnt;
  logic                     r_drain_cnt;
  logic [c_row_w-1:0]       r_out_row;
  logic                     r_signed;
  logic                     r_p_valid;
  logic                     r_done;
  logic                     r_ovf;
  logic [ROWS*c_prod_w-1:0] r_prod;
  logic [ROWS*ACC_W-1:0]    r_acc;

  logic [ROWS*c_prod_w-1:0] w_prod_next;
  logic [ROWS*ACC_W-1:0]    w_acc_next;
  logic [ROWS-1:0]          w_sat;
  logic [c_prod_w-1:0]      w_b_ext;
  logic [ACC_W-1:0]         w_out_data;
  logic                     w_in_ready;
  logic                     w_accept;
  logic                     w_abort;
  logic                     w_out_fire;

  assign w_in_ready = (r_state == c_st_accum) && (r_beat_cnt < c_cols);
  assign w_accept   = in_valid && w_in_ready && !abort;
  assign w_abort    = abort && (r_state != c_st_idle);
  assign w_out_fire = out_valid && out_ready && !abort;
  assign w_b_ext    = {{DATA_W{r_signed & in_b[DATA_W-1]}}, in_b};

  // Operands are sign/zero-extended to the product width so one unsigned
  // multiplier serves both modes; the low 2*DATA_W bits are exact.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [DATA_W-1:0]   w_a;
    logic [c_prod_w-1:0] w_a_ext;
    logic [c_prod_w-1:0] w_p;
    logic [ACC_W:0]      w_p_ext;
    logic [ACC_W:0]      w_acc_ext;
    logic [ACC_W:0]      w_sum;

    assign w_a       = in_a[r*DATA_W +: DATA_W];
    assign w_a_ext   = {{DATA_W{r_signed & w_a[DATA_W-1]}}, w_a};
    assign w_prod_next[r*c_prod_w +: c_prod_w] = w_a_ext * w_b_ext;

    assign w_p       = r_prod[r*c_prod_w +: c_prod_w];
    assign w_p_ext   = {{(ACC_W+1-c_prod_w){r_signed & w_p[c_prod_w-1]}}, w_p};
    assign w_acc_ext = {r_signed & r_acc[r*ACC_W+ACC_W-1], r_acc[r*ACC_W +: ACC_W]};
    assign w_sum     = w_acc_ext + w_p_ext;
    assign w_sat[r]  = r_signed ? (w_sum[ACC_W] ^ w_sum[ACC_W-1]) : w_sum[ACC_W];
    assign w_acc_next[r*ACC_W +: ACC_W] = !w_sat[r] ? w_sum[ACC_W-1:0] :
                                          (!r_signed ? c_umax :
                                          (w_sum[ACC_W] ? c_smin : c_smax));
  end

  always_comb begin
    w_out_data = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (r_out_row == c_row_w'(r)) w_out_data = r_acc[r*ACC_W +: ACC_W];
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == c_st_output);
  assign out_data  = out_valid ? w_out_data : '0;
  assign out_row   = r_out_row;
  assign out_last  = out_valid && (r_out_row == c_last_row);
  assign busy      = (r_state != c_st_idle);
  assign done      = r_done;
  assign ovf       = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_st_idle;
      r_beat_cnt  <= '0;
      r_drain_cnt <= 1'b0;
      r_out_row   <= '0;
      r_signed    <= 1'b0;
      r_p_valid   <= 1'b0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
      r_prod      <= '0;
      r_acc       <= '0;
    end else begin
      r_done    <= 1'b0;
      r_p_valid <= w_accept;
      if (w_accept) r_prod <= w_prod_next;
      if (r_p_valid && !w_abort) begin
        r_acc <= w_acc_next;
        if (|w_sat) r_ovf <= 1'b1;
      end
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_state    <= c_st_accum;
            r_acc      <= '0;
            r_beat_cnt <= '0;
            r_ovf      <= 1'b0;
            r_signed   <= signed_mode;
          end
        end
        c_st_accum: begin
          if (w_abort) begin
            r_state <= c_st_idle;
          end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + c_cnt_w'(1);
            if (r_beat_cnt == c_last_beat) begin
              r_state     <= c_st_drain;
              r_drain_cnt <= 1'b0;
            end
          end
        end
        c_st_drain: begin
          // Two flush cycles let the last product reach its accumulator.
          if (w_abort) r_state <= c_st_idle;
          else if (r_drain_cnt) r_state <= c_st_output;
          else r_drain_cnt <= 1'b1;
        end
        c_st_output: begin
          if (w_abort) begin
            r_state   <= c_st_idle;
            r_out_row <= '0;
          end else if (w_out_fire) begin
            if (r_out_row == c_last_row) begin
              r_state   <= c_st_idle;
              r_out_row <= '0;
              r_done    <= 1'b1;
            end else begin
              r_out_row <= r_out_row + c_row_w'(1);
            end
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_matvec_engine.sv
`default_nettype none
// Directed-vector bench for matvec_engine: default build plus a 16-bit
// accumulator twin driven with identical stimulus.
module tb_matvec_engine;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int DW   = 8;

  logic clk = 1'b0;
  logic rst, start, signed_mode, abort, in_valid, out_ready;
  logic [ROWS*DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic in_ready, out_valid, out_last, busy, done, ovf;
  logic [23:0] out_data;
  logic [2:0] out_row;
  logic in_ready16, out_valid16, out_last16, busy16, done16, ovf16;
  logic [15:0] out_data16;
  logic [2:0] out_row16;

  matvec_engine dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_last(out_last), .busy(busy), .done(done), .ovf(ovf)
  );

  matvec_engine #(.ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16), .out_row(out_row16),
    .out_last(out_last16), .busy(busy16), .done(done16), .ovf(ovf16)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [23:0] e24;
    logic [15:0] e16;
    bit          o24;
    bit          o16;
    int          vpct;
    int          rpct;
  } vec_t;

  vec_t        vt[8];
  logic [DW-1:0] ja[ROWS][COLS];
  logic [DW-1:0] jb[COLS];
  logic [23:0] e24[ROWS];
  logic [15:0] e16[ROWS];
  bit          eo24, eo16;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fill_const(input logic [7:0] a, input logic [7:0] b);
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < COLS; k++) ja[r][k] = a;
    for (int k = 0; k < COLS; k++) jb[k] = b;
  endtask

  // Reference: exact integer MAC with a clamp after every addition.
  task automatic model(input bit sm);
    longint a, b, acc, lo, hi;
    int aw;
    eo24 = 0;
    eo16 = 0;
    for (int w = 0; w < 2; w++) begin
      aw = (w == 1) ? 16 : 24;
      lo = sm ? -(longint'(1) << (aw - 1)) : 0;
      hi = sm ? (longint'(1) << (aw - 1)) - 1 : (longint'(1) << aw) - 1;
      for (int r = 0; r < ROWS; r++) begin
        acc = 0;
        for (int k = 0; k < COLS; k++) begin
          a = sm ? longint'($signed(ja[r][k])) : longint'(ja[r][k]);
          b = sm ? longint'($signed(jb[k])) : longint'(jb[k]);
          acc = acc + a * b;
          if (acc > hi || acc < lo) begin
            acc = (acc > hi) ? hi : lo;
            if (w == 1) eo16 = 1; else eo24 = 1;
          end
        end
        if (w == 1) e16[r] = acc[15:0]; else e24[r] = acc[23:0];
      end
    end
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, " flags"}, {in_ready, out_valid, out_last, busy, done, ovf}, 0);
    chk({tag, " flags16"}, {in_ready16, out_valid16, out_last16, busy16, done16, ovf16}, 0);
    chk({tag, " out_data"}, out_data, 0);
    chk({tag, " out_data16"}, out_data16, 0);
    chk({tag, " out_row"}, {out_row, out_row16}, 0);
  endtask

  task automatic run_job(input bit sm, input int vpct, input int rpct,
                         input int abort_beat, input int rst_row, input string tag);
    int k, lat, row, guard;
    bit acc_now, fire, saw_done;
    @(negedge clk);
    chk({tag, " idle_in_ready"}, in_ready, 0);
    start = 1; signed_mode = sm; in_valid = 1; in_a = '0; in_b = '0;
    @(negedge clk);
    start = 0; signed_mode = ~sm; in_valid = 0;
    chk({tag, " ovf_cleared"}, {ovf, ovf16}, 0);
    chk({tag, " busy"}, busy, 1);
    k = 0; guard = 0;
    while (k < COLS && guard < 1000) begin
      guard++;
      for (int r = 0; r < ROWS; r++) in_a[r*DW +: DW] = ja[r][k];
      in_b = jb[k];
      if (k == abort_beat) begin
        abort = 1; in_valid = 1;
        @(negedge clk);
        abort = 0; in_valid = 0;
        chk({tag, " after_abort"}, {busy, in_ready, out_valid, busy16}, 0);
        saw_done = 0;
        repeat (6) begin
          if (done || done16) saw_done = 1;
          @(negedge clk);
        end
        chk({tag, " no_done"}, saw_done, 0);
        return;
      end
      in_valid = ($urandom_range(99) >= vpct);
      acc_now = in_valid && in_ready;
      @(negedge clk);
      if (acc_now) k++;
    end
    in_valid = 0;
    chk({tag, " beats"}, k, COLS);
    chk({tag, " drain_in_ready"}, in_ready, 0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, 3);
    row = 0; guard = 0;
    while (row < ROWS && guard < 1000) begin
      guard++;
      chk({tag, " out_valid"}, {out_valid, out_valid16}, 3);
      if (!out_valid) break;
      if (row == rst_row) begin
        rst = 1;
        @(negedge clk);
        rst = 0;
        rst_checks({tag, " mid_rst"});
        out_ready = 1;
        return;
      end
      out_ready = ($urandom_range(99) >= rpct);
      chk({tag, " out_row"}, out_row, row);
      chk({tag, " out_data"}, out_data, e24[row]);
      chk({tag, " out_data16"}, out_data16, e16[row]);
      chk({tag, " out_last"}, {out_last, out_last16}, (row == ROWS - 1) ? 3 : 0);
      fire = out_ready;
      @(negedge clk);
      if (fire) row++;
    end
    out_ready = 1;
    chk({tag, " rows"}, row, ROWS);
    chk({tag, " done"}, {done, done16}, 3);
    chk({tag, " end_idle"}, {out_valid, busy}, 0);
    chk({tag, " ovf"}, ovf, eo24);
    chk({tag, " ovf16"}, ovf16, eo16);
    @(negedge clk);
    chk({tag, " done_pulse"}, {done, done16}, 0);
  endtask

  initial begin
    rst = 1; start = 0; signed_mode = 0; abort = 0; in_valid = 0; out_ready = 1;
    in_a = '0; in_b = '0;
    repeat (3) @(negedge clk);
    rst_checks("reset");
    rst = 0;

    vt[0] = '{1'b0, 8'd1,   8'd2,   24'd16,     16'd16,     1'b0, 1'b0, 0,  0};
    vt[1] = '{1'b1, 8'h80,  8'h80,  24'h020000, 16'h7FFF,   1'b0, 1'b1, 30, 30};
    vt[2] = '{1'b1, 8'h80,  8'h7F,  24'hFE0400, 16'h8000,   1'b0, 1'b1, 30, 30};
    vt[3] = '{1'b0, 8'hFF,  8'hFF,  24'h07F008, 16'hFFFF,   1'b0, 1'b1, 30, 30};
    vt[4] = '{1'b0, 8'd3,   8'd5,   24'd120,    16'd120,    1'b0, 1'b0, 30, 30};
    vt[5] = '{1'b1, 8'hFF,  8'h03,  24'hFFFFE8, 16'hFFE8,   1'b0, 1'b0, 30, 30};
    vt[6] = '{1'b1, 8'h7F,  8'h7F,  24'h01F808, 16'h7FFF,   1'b0, 1'b1, 30, 30};
    vt[7] = '{1'b0, 8'd0,   8'd200, 24'd0,      16'd0,      1'b0, 1'b0, 30, 30};

    for (int i = 0; i < 8; i++) begin
      fill_const(vt[i].a, vt[i].b);
      for (int r = 0; r < ROWS; r++) begin
        e24[r] = vt[i].e24;
        e16[r] = vt[i].e16;
      end
      eo24 = vt[i].o24;
      eo16 = vt[i].o16;
      run_job(vt[i].sm, vt[i].vpct, vt[i].rpct, -1, -1, $sformatf("vec%0d", i));
    end

    // Abort coinciding with start in IDLE must not block the start.
    @(negedge clk);
    start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    chk("idle_abort busy", busy, 1);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("accum_abort busy", busy, 0);

    fill_const(8'd9, 8'd9);
    run_job(1'b0, 0, 0, 4, -1, "abort");
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < COLS; k++) ja[r][k] = (r == k) ? 8'd1 : 8'd0;
    for (int k = 0; k < COLS; k++) jb[k] = 8'(k + 1);
    for (int r = 0; r < ROWS; r++) begin
      e24[r] = 24'(r + 1);
      e16[r] = 16'(r + 1);
    end
    eo24 = 0; eo16 = 0;
    run_job(1'b0, 20, 20, -1, -1, "ident");

    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < COLS; k++) ja[r][k] = 8'(r + k + 200);
    for (int k = 0; k < COLS; k++) jb[k] = 8'd250;
    model(1'b0);
    run_job(1'b0, 0, 0, -1, 4, "rst_mid");
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < COLS; k++) ja[r][k] = 8'(r * 16 + k);
    for (int k = 0; k < COLS; k++) jb[k] = 8'(8'hF0 + k);
    model(1'b1);
    run_job(1'b1, 0, 0, -1, -1, "post_rst");

    for (int j = 0; j < 100; j++) begin
      bit sm;
      sm = 1'($urandom_range(1));
      for (int r = 0; r < ROWS; r++)
        for (int k = 0; k < COLS; k++) ja[r][k] = 8'($urandom_range(255));
      for (int k = 0; k < COLS; k++) jb[k] = 8'($urandom_range(255));
      model(sm);
      run_job(sm, 50, 50, -1, -1, $sformatf("rand%0d", j));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
